keypad_unlock_ctrl: RTL
=======================

KEYPAD_UNLOCK_CTRL -- requirements
Module: keypad_unlock_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEFAULT_CODE, 16'h1234: four BCD digits loaded at reset; most significant nibble is entered first.
- UNLOCK_CYC, 250_000_000: length of the unlock window in clk cycles.
- TIMEOUT_CYC, 500_000_000: maximum idle gap between keys during entry, in clk cycles.
- MAX_FAIL, 3: consecutive wrong codes that trigger lockout.
- LOCKOUT_CYC, 1_500_000_000: lockout duration in clk cycles.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1: single system clock.
- reset, in, 1: asynchronous, active-high reset.
- key_valid, in, 1: one-cycle strobe qualifying key_code.
- key_code, in, 4: 0-9 digit, 4'hA clear (*), 4'hB enter (#), 4'hC-F ignored.
- code_we, in, 1: write strobe for a new stored code.
- code_wdata, in, 16: new code as four BCD nibbles.
- lock_cmd, out, 1: 1 = lock engaged, 0 = released.
- unlocked, out, 1: high during the unlock window.
- lockout, out, 1: high during lockout.
- digit_cnt, out, 3: digits held in the entry buffer, 0-4.
- fail_cnt, out, 2: consecutive failures.

Function
REQ-003 The FSM SHALL have states IDLE, ENTRY, CHECK, OPEN and LOCKOUT, all registered on the rising edge of clk.
REQ-004 In IDLE, a digit key SHALL shift into the 16-bit entry buffer (buf <= {buf[11:0], digit}), set digit_cnt to 1 and go to ENTRY.
REQ-005 In ENTRY, each digit key SHALL shift in and increment digit_cnt, saturating at 4; digits after the fourth SHALL shift in, so the buffer always holds the last four digits.
REQ-006 A clear key SHALL, in IDLE or ENTRY, zero the buffer and digit_cnt and return the FSM to IDLE with no change to fail_cnt.
REQ-007 An enter key in ENTRY SHALL go to CHECK on the next cycle; an enter key in IDLE SHALL be ignored.
REQ-008 CHECK SHALL last exactly one cycle: a match requires digit_cnt==4 and buf==stored code; the FSM then goes to OPEN, otherwise it counts a failure.
REQ-009 A match SHALL clear fail_cnt, load the timer with UNLOCK_CYC-1 and drive lock_cmd=0 and unlocked=1 from the first OPEN cycle.
REQ-010 A failure SHALL increment fail_cnt; if the new value equals MAX_FAIL, the FSM SHALL go to LOCKOUT with the timer at LOCKOUT_CYC-1, otherwise it SHALL go to IDLE.
REQ-011 CHECK SHALL clear the buffer and digit_cnt on both outcomes.
REQ-012 OPEN SHALL last exactly UNLOCK_CYC cycles and then return to IDLE with lock_cmd=1.
REQ-013 In OPEN, an enter key SHALL re-lock immediately, returning to IDLE on the next cycle; all other keys SHALL be ignored.
REQ-014 LOCKOUT SHALL ignore all keys and code writes, hold lockout=1 and lock_cmd=1 for exactly LOCKOUT_CYC cycles, then clear fail_cnt and go to IDLE.
REQ-015 In ENTRY, the idle timer SHALL reload with TIMEOUT_CYC-1 on every key. If it expires, the buffer and digit_cnt SHALL clear, the FSM SHALL return to IDLE, and no failure SHALL be counted.
REQ-016 code_we SHALL update the stored code only in IDLE or OPEN. A write on the same cycle as a CHECK SHALL be dropped.
REQ-017 When key_valid is high on the same cycle as a timer expiry, the expiry SHALL take priority and the key SHALL be dropped.
REQ-018 lock_cmd SHALL be 1 in every state except OPEN. All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-019 While reset is high, the design SHALL force: state IDLE; lock_cmd=1; unlocked=0; lockout=0; digit_cnt=0; fail_cnt=0; buffer 0; timer 0; stored code DEFAULT_CODE.
REQ-020 A reset asserted mid-OPEN or mid-LOCKOUT SHALL take effect asynchronously, so lock_cmd=1 with no clock edge required.

Structure
REQ-021 A shared package keypad_pkg SHALL hold the FSM state enum and the key constants KEY_CLEAR=4'hA and KEY_ENTER=4'hB.
REQ-022 A single down-counter sub-module, cycle_timer (load, load_val, expired; 31-bit width), SHALL serve the OPEN, ENTRY-timeout and LOCKOUT states.

Verification
REQ-023 Run benches with UNLOCK_CYC=20, TIMEOUT_CYC=50, LOCKOUT_CYC=100.
REQ-024 The bench SHALL cover these scenarios:
- Keys 1,2,3,4,# -> unlocked=1 and lock_cmd=0 for exactly 20 cycles starting 2 cycles after #, then lock_cmd=1.
- Keys 1,2,3,5,# three times -> fail_cnt 1 then 2, then lockout=1 for 100 cycles; the correct code entered during lockout is ignored; fail_cnt=0 afterwards.
- Keys 9,1,2,3,4,# -> match, since the last four digits are used; keys 1,2,# -> failure, with digit_cnt=2 at enter.
- Keys 1,2, then 50 idle cycles -> digit_cnt returns to 0, fail_cnt unchanged, state IDLE.
- code_we with 16'h0007 in IDLE, then keys 0,0,0,7,# -> unlock; the old code 1,2,3,4,# -> failure.
- reset pulsed on cycle 5 of OPEN -> lock_cmd=1 asynchronously, and all outputs at their reset values.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad unlock controller.
// Holds the FSM state enum, special key codes and the timer width.
package keypad_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StEntry,
        StCheck,
        StOpen,
        StLockout
    } state_e;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    // Wide enough for the longest window (1.5e9 cycles) as an unsigned count.
    localparam int unsigned TIMER_W = 31;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter shared by the OPEN, entry-timeout and LOCKOUT windows.
// expired is high whenever the count sits at zero.
module cycle_timer
    import keypad_pkg::*;
#(
    parameter int unsigned WIDTH = TIMER_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/keypad_unlock_ctrl.sv
// Four-digit keypad lock: collects digits, checks them against a writable code,
// opens for a timed window and locks out after repeated wrong codes.
module keypad_unlock_ctrl
    import keypad_pkg::*;
#(
    parameter logic [15:0] DEFAULT_CODE = 16'h1234,
    parameter int unsigned UNLOCK_CYC   = 250_000_000,
    parameter int unsigned TIMEOUT_CYC  = 500_000_000,
    parameter int unsigned MAX_FAIL     = 3,
    parameter int unsigned LOCKOUT_CYC  = 1_500_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        code_we,
    input  logic [15:0] code_wdata,
    output logic        lock_cmd,
    output logic        unlocked,
    output logic        lockout,
    output logic [2:0]  digit_cnt,
    output logic [1:0]  fail_cnt
);

    localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYC - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYC - 1);
    localparam logic [1:0]         FAIL_LIMIT   = 2'(MAX_FAIL);

    state_e               state_q;
    logic [15:0]          entry_buf_q;
    logic [15:0]          code_q;

    logic                 key_digit;
    logic                 key_clear;
    logic                 key_enter;
    logic                 code_match;
    logic [1:0]           fail_next;

    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_val;
    logic                 timer_expired;

    cycle_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    always_comb begin
        key_digit  = key_valid && is_digit(key_code);
        key_clear  = key_valid && (key_code == KEY_CLEAR);
        key_enter  = key_valid && (key_code == KEY_ENTER);
        code_match = (digit_cnt == 3'd4) && (entry_buf_q == code_q);
        fail_next  = fail_cnt + 2'd1;
    end

    // Timer reloads: first digit, any further non-clear/enter key in ENTRY,
    // and the CHECK outcome that opens or locks out.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        unique case (state_q)
            StIdle: begin
                if (key_digit) begin
                    timer_load = 1'b1;
                    timer_val  = TIMEOUT_LOAD;
                end
            end
            StEntry: begin
                if (!timer_expired && key_valid && !key_clear && !key_enter) begin
                    timer_load = 1'b1;
                    timer_val  = TIMEOUT_LOAD;
                end
            end
            StCheck: begin
                if (code_match) begin
                    timer_load = 1'b1;
                    timer_val  = UNLOCK_LOAD;
                end else if (fail_next == FAIL_LIMIT) begin
                    timer_load = 1'b1;
                    timer_val  = LOCKOUT_LOAD;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            entry_buf_q <= '0;
            code_q      <= DEFAULT_CODE;
            digit_cnt   <= '0;
            fail_cnt    <= '0;
            lock_cmd    <= 1'b1;
            unlocked    <= 1'b0;
            lockout     <= 1'b0;
        end else begin
            if (code_we && (state_q == StIdle || state_q == StOpen)) begin
                code_q <= code_wdata;
            end
            unique case (state_q)
                StIdle: begin
                    if (key_digit) begin
                        entry_buf_q <= {entry_buf_q[11:0], key_code};
                        digit_cnt   <= 3'd1;
                        state_q     <= StEntry;
                    end else if (key_clear) begin
                        entry_buf_q <= '0;
                        digit_cnt   <= '0;
                    end
                end
                StEntry: begin
                    // Expiry outranks any key arriving on the same cycle.
                    if (timer_expired || key_clear) begin
                        entry_buf_q <= '0;
                        digit_cnt   <= '0;
                        state_q     <= StIdle;
                    end else if (key_enter) begin
                        state_q <= StCheck;
                    end else if (key_digit) begin
                        entry_buf_q <= {entry_buf_q[11:0], key_code};
                        if (digit_cnt != 3'd4) begin
                            digit_cnt <= digit_cnt + 3'd1;
                        end
                    end
                end
                StCheck: begin
                    entry_buf_q <= '0;
                    digit_cnt   <= '0;
                    if (code_match) begin
                        fail_cnt <= '0;
                        lock_cmd <= 1'b0;
                        unlocked <= 1'b1;
                        state_q  <= StOpen;
                    end else begin
                        fail_cnt <= fail_next;
                        if (fail_next == FAIL_LIMIT) begin
                            lockout <= 1'b1;
                            state_q <= StLockout;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StOpen: begin
                    if (timer_expired || key_enter) begin
                        lock_cmd <= 1'b1;
                        unlocked <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                StLockout: begin
                    if (timer_expired) begin
                        fail_cnt <= '0;
                        lockout  <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: begin
                    lock_cmd <= 1'b1;
                    unlocked <= 1'b0;
                    lockout  <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

endmodule
